// File: rtl/jpeg_stream_reader_pkg.sv
// Shared types and JPEG marker constants for the FIFO drain / byte stream reader.
package jpeg_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_EOI           = 8'hD9;

endpackage

// File: rtl/jpeg_stream_reader.sv
// Drains the JPEG byte FIFO onto a valid/ready byte stream, flags the EOI
// marker byte with out_last, and reports the byte count of each finished frame.
module jpeg_stream_reader
    import jpeg_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  frame_bytes,
    output logic                  frame_done
);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   counter;
    logic                   prev_ff;
    logic                   accept;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign accept = out_valid & out_ready;

    // State register; reset and abort both force IDLE.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake strobes; the SETTLE cycle pops the FIFO head.
    always_comb begin
        state_next = state;
        fifo_read  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                fifo_read  = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte capture, EOI detection, per-frame counting and frame_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data    <= '0;
            out_last    <= 1'b0;
            counter     <= '0;
            prev_ff     <= 1'b0;
            frame_bytes <= '0;
            frame_done  <= 1'b0;
        end else if (abort) begin
            out_data   <= '0;
            out_last   <= 1'b0;
            counter    <= '0;
            prev_ff    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == SETTLE) begin
                out_data <= fifo_data;
                out_last <= (fifo_data == DATA_WIDTH'(JPEG_EOI)) && prev_ff;
            end
            if (accept) begin
                if (out_last) begin
                    frame_bytes <= sat_inc(counter);
                    counter     <= '0;
                    prev_ff     <= 1'b0;
                    frame_done  <= 1'b1;
                end else begin
                    counter <= sat_inc(counter);
                    prev_ff <= (out_data == DATA_WIDTH'(JPEG_MARKER_PREFIX));
                end
            end
        end
    end

endmodule

// File: doc/jpeg_stream_reader.md
# jpeg_stream_reader

Drain side of the JPEG byte FIFO: pops encoded bytes from the single-clock FIFO (registered read data, one-cycle-late head), presents them on a valid/ready byte stream toward the ESP32 host link, and flags end of frame on the JPEG EOI marker (0xFF 0xD9). Sits between the encoder output FIFO and the host transfer logic in the OV7670/ESP32 build.

## Interface
- DATA_WIDTH, 8, byte width of FIFO and stream
- CNT_WIDTH, 20, width of per-frame byte counter
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- abort  in  1  synchronous flush: drop held byte, clear counter/EOI state, return to IDLE
- fifo_data  in  DATA_WIDTH  FIFO registered head data
- fifo_empty  in  1  FIFO empty flag
- fifo_read  out  1  FIFO pop strobe, exactly one cycle per byte
- out_data  out  DATA_WIDTH  stream byte
- out_valid  out  1  byte valid
- out_ready  in  1  host accepts byte
- out_last  out  1  high with out_valid when out_data is the 0xD9 of EOI
- frame_bytes  out  CNT_WIDTH  byte count of last completed frame, EOI included
- frame_done  out  1  one-cycle pulse after EOI byte accepted

## Operation
- FSM states IDLE, SETTLE, SEND; reset and abort enter IDLE.
- IDLE: if !fifo_empty -> SETTLE; else stay.
- SETTLE (one cycle): fifo_read = 1; at end of cycle capture fifo_data into out_data, compute out_last; -> SEND.
- SEND: out_valid = 1; out_data/out_last stable until out_ready; on out_valid & out_ready -> IDLE.
- fifo_read is high only in SETTLE; never asserted while fifo_empty was seen high in the preceding IDLE cycle.
- EOI tracking: flag prev_ff updated on each accepted byte: set if byte == 0xFF, cleared otherwise. out_last = (captured byte == 0xD9) & prev_ff. Stuffed 0xFF 0x00 clears flag; fill run 0xFF 0xFF 0xD9 still yields out_last on 0xD9.
- Byte counter increments on each accepted byte, saturates at all-ones. On accepted out_last byte: frame_bytes <= counter + 1 (saturating), counter <= 0, prev_ff <= 0, frame_done pulses next cycle.
- abort beats every other event in the same cycle; frame_bytes keeps its last value on abort.

## Timing
- Reset values: fifo_read 0, out_valid 0, out_last 0, out_data 0, frame_bytes 0, frame_done 0; state IDLE; counter 0; prev_ff 0.
- FIFO contract: head visible on fifo_data one cycle after pointer/contents change; IDLE→SETTLE spacing guarantees valid capture, both after write to empty FIFO and after a preceding pop.
- Latency: fifo_empty falls at edge E -> fifo_read high in cycle E+1..E+2 -> out_valid high from edge E+2.
- Peak throughput one byte per 3 cycles with out_ready held high.
- out_valid never drops without handshake (except reset/abort); out_data unchanged while out_valid & !out_ready.
- frame_done: high exactly one cycle, the cycle after the EOI handshake edge.
- fifo_empty rising during SEND has no effect on the held byte.

## Structure
- Shared package: state enum (IDLE, SETTLE, SEND), marker constants JPEG_MARKER_PREFIX = 8'hFF, JPEG_EOI = 8'hD9.
- Single flat module; no sub-module warranted.

## Test plan
- Write 0xAB into empty FIFO, out_ready=1 -> one fifo_read pulse, out_data=0xAB, out_last=0, three cycles per byte on back-to-back bytes.
- Stream FF 00 12 FF D9 -> out_last only on 0xD9, frame_bytes=5, frame_done single pulse, counter restarts at 0.
- Stream FF FF D9 -> out_last on D9, frame_bytes=3.
- Hold out_ready=0 for 10 cycles in SEND -> out_data stable, no extra fifo_read, FIFO count unchanged.
- Assert abort during SEND with byte 0x55 held -> out_valid 0 next cycle, byte lost, counter 0, frame_bytes retains prior value; reset mid-frame -> all outputs at reset values.
- Drain 512-byte full FIFO with random out_ready -> exactly 512 fifo_read pulses, byte order preserved, no pop while empty.
